quad_encoder_counter: RTL and testbench

Quadrature front end for the drive encoder: synchronises and glitch-filters raw A/B, decodes 4x quadrature into a signed position count, and measures signed velocity over a fixed window. Sits directly upstream of the drive block's cm conversion and motor control, which consume c_out, dir and velocity. Illegal transitions are flagged and never counted.

---
 rtl/quad_encoder_counter.sv | 173 +++++++++++++++++
 tb/tb_quad_encoder_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_counter.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_counter
// Brief    : Synchronised, glitch-filtered 4x quadrature decoder with signed
//            wrapping position count and windowed, saturating signed velocity.
// Revision : 1.0 - initial release
// ============================================================================
module quad_encoder_counter #(
  parameter int COUNT_W    = 24,
  parameter int FILT_LEN   = 4,
  parameter int VEL_WINDOW = 500000,
  parameter int VEL_W      = 16
) (
  input  logic                      CLOCK_50,
  input  logic                      rst_n,
  input  logic                      A,
  input  logic                      B,
  input  logic                      clr,
  input  logic                      err_clr,
  output logic signed [COUNT_W-1:0] c_out,
  output logic                      dir,
  output logic                      step_pulse,
  output logic                      err,
  output logic signed [VEL_W-1:0]   velocity,
  output logic                      vel_valid
);

  localparam int c_filt_w  = $clog2(FILT_LEN);
  localparam int c_prime_w = $clog2(FILT_LEN + 3);
  localparam int c_win_w   = $clog2(VEL_WINDOW);
  localparam logic signed [VEL_W:0] c_vmax = {2'b00, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W:0] c_vmin = -c_vmax;

  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {A, B};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic                s1_q;
    logic                s2_q;
    logic                filt_q;
    logic [c_filt_w-1:0] cnt_q;

    always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q <= w_raw[ch];
        s2_q <= s1_q;
        if (s2_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == c_filt_w'(FILT_LEN - 1)) begin
          filt_q <= s2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign w_filt[ch] = filt_q;
  end

  logic [1:0]               prev_q;
  logic [c_prime_w-1:0]     prime_cnt_q;
  logic                     primed_q;
  logic signed [COUNT_W-1:0] c_out_q, c_out_d;
  logic                     dir_q, dir_d;
  logic                     step_q, step_d;
  logic                     err_q, err_d;
  logic [c_win_w-1:0]       win_q, win_d;
  logic signed [VEL_W-1:0]  acc_q, acc_d;
  logic signed [VEL_W-1:0]  vel_q, vel_d;
  logic                     vel_valid_q, vel_valid_d;

  // Gray position along the forward sequence 00->10->11->01 as {B, A^B}.
  logic [1:0] w_pos_prev, w_pos_curr, w_delta;
  logic       w_fwd, w_rev, w_ill, w_cnt_step;
  logic       w_win_last;
  logic signed [VEL_W:0]   w_vstep, w_vsum;
  logic signed [VEL_W-1:0] w_vsat;

  assign w_pos_prev = {prev_q[0], prev_q[1] ^ prev_q[0]};
  assign w_pos_curr = {w_filt[0], w_filt[1] ^ w_filt[0]};
  assign w_delta    = w_pos_curr - w_pos_prev;
  assign w_fwd      = primed_q && (w_delta == 2'd1);
  assign w_rev      = primed_q && (w_delta == 2'd3);
  assign w_ill      = primed_q && (w_delta == 2'd2);
  assign w_cnt_step = (w_fwd || w_rev) && !clr;
  assign w_win_last = (win_q == c_win_w'(VEL_WINDOW - 1));

  always_comb begin
    w_vstep = '0;
    if (w_cnt_step) begin
      w_vstep = w_fwd ? (VEL_W+1)'(1) : '1;
    end
    w_vsum = {acc_q[VEL_W-1], acc_q} + w_vstep;
    w_vsat = w_vsum[VEL_W-1:0];
    if (w_vsum > c_vmax) begin
      w_vsat = c_vmax[VEL_W-1:0];
    end else if (w_vsum < c_vmin) begin
      w_vsat = c_vmin[VEL_W-1:0];
    end
  end

  always_comb begin
    c_out_d     = c_out_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = err_q;
    if (clr) begin
      c_out_d = '0;
    end else if (w_fwd || w_rev) begin
      step_d  = 1'b1;
      dir_d   = w_fwd;
      c_out_d = w_fwd ? c_out_q + 1'b1 : c_out_q - 1'b1;
    end
    if (w_ill) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
    win_d       = w_win_last ? '0 : win_q + 1'b1;
    acc_d       = w_win_last ? '0 : w_vsat;
    vel_d       = w_win_last ? w_vsat : vel_q;
    vel_valid_d = (win_d == c_win_w'(VEL_WINDOW - 1));
  end

  // Decoding stays gated one edge past the first possible filter settle,
  // so a level held through reset never reads as an illegal jump from 00.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      prev_q      <= '0;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
      c_out_q     <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      prev_q <= w_filt;
      if (!primed_q) begin
        prime_cnt_q <= prime_cnt_q + 1'b1;
        primed_q    <= (prime_cnt_q == c_prime_w'(FILT_LEN + 2));
      end
      c_out_q     <= c_out_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
    end
  end

  assign c_out      = c_out_q;
  assign dir        = dir_q;
  assign step_pulse = step_q;
  assign err        = err_q;
  assign velocity   = vel_q;
  assign vel_valid  = vel_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_encoder_counter
// Brief    : Scoreboard bench: expected steps and per-window velocities are
//            queued as stimulus is driven and matched against DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_counter;

  localparam int COUNT_W    = 8;
  localparam int FILT_LEN   = 4;
  localparam int VEL_WINDOW = 100;
  localparam int VEL_W      = 4;
  localparam int LAT        = FILT_LEN + 3;
  localparam int VMAX       = (1 << (VEL_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n, A, B, clr, err_clr;
  logic signed [COUNT_W-1:0] c_out;
  logic                      dir, step_pulse, err, vel_valid;
  logic signed [VEL_W-1:0]   velocity;

  quad_encoder_counter #(
    .COUNT_W   (COUNT_W),
    .FILT_LEN  (FILT_LEN),
    .VEL_WINDOW(VEL_WINDOW),
    .VEL_W     (VEL_W)
  ) u_dut (
    .CLOCK_50  (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .clr       (clr),
    .err_clr   (err_clr),
    .c_out     (c_out),
    .dir       (dir),
    .step_pulse(step_pulse),
    .err       (err),
    .velocity  (velocity),
    .vel_valid (vel_valid)
  );

  always #10 clk = ~clk;

  typedef struct {
    int arrive;
    int pos;
    int dir;
  } step_t;

  step_t sq[$];
  int    wexp[int];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    vv_count = 0;
  bit    vpend    = 1'b0;
  int    vwin     = 0;
  logic [1:0] ab;
  int    exp_pos;
  int    exp_dir;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int wrap_cnt(input int v);
    logic signed [COUNT_W-1:0] t;
    t = COUNT_W'(v);
    return int'(t);
  endfunction

  function automatic logic [1:0] next_ab(input logic [1:0] cur, input bit fwd);
    case (cur)
      2'b00:   return fwd ? 2'b10 : 2'b01;
      2'b10:   return fwd ? 2'b11 : 2'b00;
      2'b11:   return fwd ? 2'b01 : 2'b10;
      default: return fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input bit fwd, input int hold);
    step_t e;
    int    w, cur, nv;
    ab      = next_ab(ab, fwd);
    A       = ab[1];
    B       = ab[0];
    exp_pos = wrap_cnt(exp_pos + (fwd ? 1 : -1));
    exp_dir = fwd ? 1 : 0;
    e.arrive = cyc + LAT;
    e.pos    = exp_pos;
    e.dir    = exp_dir;
    sq.push_back(e);
    w   = (cyc + LAT - 1) / VEL_WINDOW;
    cur = wexp.exists(w) ? wexp[w] : 0;
    nv  = cur + (fwd ? 1 : -1);
    if (nv > VMAX) nv = VMAX;
    if (nv < -VMAX) nv = -VMAX;
    wexp[w] = nv;
    tick(hold);
  endtask

  task automatic align_window();
    while ((cyc % VEL_WINDOW) != 0) tick(1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (vpend) begin
        check("velocity", int'(velocity), wexp.exists(vwin) ? wexp[vwin] : 0);
        vpend <= 1'b0;
      end
      while (sq.size() > 0 && sq[0].arrive < cyc) begin
        check("step_missing", cyc, sq[0].arrive);
        void'(sq.pop_front());
      end
      if (step_pulse) begin
        if (sq.size() == 0) begin
          check("step_spurious", int'(step_pulse), 0);
        end else begin
          check("step_cycle", cyc, sq[0].arrive);
          check("step_c_out", int'(c_out), sq[0].pos);
          check("step_dir", int'(dir), sq[0].dir);
          void'(sq.pop_front());
        end
      end
      if (vel_valid) begin
        check("vel_valid_cycle", cyc % VEL_WINDOW, VEL_WINDOW - 1);
        vpend    <= 1'b1;
        vwin     <= cyc / VEL_WINDOW;
        vv_count <= vv_count + 1;
      end
    end
  end

  initial begin
    rst_n = 1'b0; A = 1'b1; B = 1'b1; clr = 1'b0; err_clr = 1'b0;
    ab = 2'b11; exp_pos = 0; exp_dir = 0;
    tick(4);
    check("rst_c_out", int'(c_out), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_step", int'(step_pulse), 0);
    check("rst_err", int'(err), 0);
    check("rst_velocity", int'(velocity), 0);
    check("rst_vel_valid", int'(vel_valid), 0);
    rst_n = 1'b1;
    tick(20);
    check("idle_c_out", int'(c_out), 0);
    check("idle_err", int'(err), 0);

    for (int i = 0; i < 16; i++) step(1'b1, 10);
    check("fwd_c_out", int'(c_out), 16);
    check("fwd_dir", int'(dir), 1);
    for (int i = 0; i < 8; i++) step(1'b0, 10);
    check("rev_c_out", int'(c_out), 8);
    check("rev_dir", int'(dir), 0);

    // Glitches of 2 and 3 cycles on A must be filtered out.
    A = 1'b0; tick(2); A = 1'b1; tick(12);
    A = 1'b0; tick(3); A = 1'b1; tick(12);
    check("glitch_c_out", int'(c_out), 8);

    step(1'b0, 10);
    step(1'b0, 10);
    check("at00_c_out", int'(c_out), 6);

    A = 1'b1; B = 1'b1; ab = 2'b11;
    tick(LAT - 1);
    check("ill_err_early", int'(err), 0);
    tick(1);
    check("ill_err", int'(err), 1);
    check("ill_c_out", int'(c_out), 6);
    check("ill_dir", int'(dir), 0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("err_clr", int'(err), 0);

    A = 1'b0; B = 1'b0; ab = 2'b00;
    tick(LAT - 1);
    check("ill2_err_early", int'(err), 0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("err_set_wins", int'(err), 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("err_clr2", int'(err), 0);
    tick(3);

    clr = 1'b1; tick(1); clr = 1'b0;
    exp_pos = 0;
    check("clr_c_out", int'(c_out), 0);
    for (int i = 0; i < 127; i++) step(1'b1, 5);
    tick(5);
    check("max_c_out", int'(c_out), 127);
    step(1'b1, 10);
    check("wrap_pos_c_out", int'(c_out), -128);
    step(1'b0, 10);
    check("wrap_neg_c_out", int'(c_out), 127);
    check("wrap_neg_dir", int'(dir), 0);

    // Forward step landing on the same edge as clr: discarded.
    ab = next_ab(ab, 1'b1); A = ab[1]; B = ab[0];
    tick(LAT - 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    exp_pos = 0;
    check("clr_step_c_out", int'(c_out), 0);
    check("clr_step_pulse", int'(step_pulse), 0);
    check("clr_step_dir", int'(dir), 0);
    tick(5);

    align_window();
    for (int i = 0; i < 7; i++) step(1'b1, 6);
    align_window();
    for (int i = 0; i < 20; i++) step(1'b1, 4);
    align_window();
    for (int i = 0; i < 20; i++) step(1'b0, 4);
    align_window();
    for (int i = 0; i < 12; i++) step(1'b1, 4);
    for (int i = 0; i < 3; i++) step(1'b0, 4);
    align_window();
    tick(2 * VEL_WINDOW + 2);

    check("queue_empty", sq.size(), 0);
    check("vel_valid_count", vv_count, cyc / VEL_WINDOW);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
